// File: rtl/ro_puf_reader.sv
// rtl/ro_puf_reader.sv - RO-PUF readout: per-bit pair enable, edge counting and compare
// Evaluates one response bit at a time by racing two challenge-selected ring oscillators.
module ro_puf_reader #(
   parameter int NUM_RO   = 4,
   parameter int SEL_W    = 2,
   parameter int NUM_BITS = 4,
   parameter int CNT_W    = 16,
   parameter int SETTLE   = 8,
   parameter int WINDOW   = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [NUM_BITS*2*SEL_W-1:0]  challenge,
   input  logic [NUM_RO-1:0]            ro_in,
   output logic [NUM_RO-1:0]            ro_en,
   output logic                         busy,
   output logic                         done,
   output logic [NUM_BITS-1:0]          response,
   output logic [NUM_BITS-1:0]          tie,
   output logic [NUM_BITS-1:0]          err
);

   localparam int CH_W  = NUM_BITS*2*SEL_W;
   localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam int TMAX  = (SETTLE > WINDOW) ? SETTLE : WINDOW;
   localparam int TMR_W = $clog2(TMAX + 1);
   localparam int SEL_N = 1 << SEL_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SETTLE, S_COUNT, S_COMPARE, S_NEXT, S_DONE
   } state_t;

   state_t              state, state_n;
   logic [CH_W-1:0]     chal, chal_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [TMR_W-1:0]    timer, timer_n;
   logic [CNT_W-1:0]    cnt_a, cnt_a_n, cnt_b, cnt_b_n;
   logic [NUM_RO-1:0]   en_q, en_n;
   logic [NUM_BITS-1:0] response_q, response_n, tie_q, tie_n, err_q, err_n;

   logic [NUM_RO-1:0]   sync1, sync2, prev;
   logic [NUM_RO-1:0]   rise;
   logic [SEL_N-1:0]    rise_ext, en_ext;
   logic [SEL_W-1:0]    sel_a, sel_b;
   logic                pair_bad, hit_a, hit_b;

   // ro_in is asynchronous to clk: two flops for metastability, one more for edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= ro_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise  = sync2 & ~prev;
   assign sel_a = chal[2*SEL_W*idx +: SEL_W];
   assign sel_b = chal[2*SEL_W*idx + SEL_W +: SEL_W];

   assign pair_bad = (sel_a == sel_b) || (32'(sel_a) >= NUM_RO) || (32'(sel_b) >= NUM_RO);

   always_comb begin
      rise_ext = '0;
      rise_ext[NUM_RO-1:0] = rise;
      en_ext = '0;
      en_ext[sel_a] = 1'b1;
      en_ext[sel_b] = 1'b1;
   end

   assign hit_a = rise_ext[sel_a];
   assign hit_b = rise_ext[sel_b];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         chal       <= '0;
         idx        <= '0;
         timer      <= '0;
         cnt_a      <= '0;
         cnt_b      <= '0;
         en_q       <= '0;
         response_q <= '0;
         tie_q      <= '0;
         err_q      <= '0;
      end else begin
         state      <= state_n;
         chal       <= chal_n;
         idx        <= idx_n;
         timer      <= timer_n;
         cnt_a      <= cnt_a_n;
         cnt_b      <= cnt_b_n;
         en_q       <= en_n;
         response_q <= response_n;
         tie_q      <= tie_n;
         err_q      <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      chal_n     = chal;
      idx_n      = idx;
      timer_n    = timer;
      cnt_a_n    = cnt_a;
      cnt_b_n    = cnt_b;
      en_n       = en_q;
      response_n = response_q;
      tie_n      = tie_q;
      err_n      = err_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               chal_n     = challenge;
               idx_n      = '0;
               response_n = '0;
               tie_n      = '0;
               err_n      = '0;
               state_n    = S_SETUP;
            end
         end
         S_SETUP: begin
            // an invalid pair never powers any oscillator
            if (pair_bad) begin
               err_n[idx] = 1'b1;
               state_n    = S_NEXT;
            end else begin
               en_n    = en_ext[NUM_RO-1:0];
               cnt_a_n = '0;
               cnt_b_n = '0;
               timer_n = TMR_W'(SETTLE - 1);
               state_n = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (timer == '0) begin
               timer_n = TMR_W'(WINDOW - 1);
               state_n = S_COUNT;
            end else begin
               timer_n = timer - 1'b1;
            end
         end
         S_COUNT: begin
            if (hit_a && (cnt_a != CNT_MAX)) cnt_a_n = cnt_a + 1'b1;
            if (hit_b && (cnt_b != CNT_MAX)) cnt_b_n = cnt_b + 1'b1;
            if (timer == '0) state_n = S_COMPARE;
            else             timer_n = timer - 1'b1;
         end
         S_COMPARE: begin
            response_n[idx] = (cnt_a > cnt_b);
            tie_n[idx]      = (cnt_a == cnt_b);
            en_n            = '0;
            state_n         = S_NEXT;
         end
         S_NEXT: begin
            if (idx == IDX_W'(NUM_BITS - 1)) begin
               state_n = S_DONE;
            end else begin
               idx_n   = idx + 1'b1;
               state_n = S_SETUP;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign ro_en    = en_q;
   assign busy     = (state != S_IDLE) && (state != S_DONE);
   assign done     = (state == S_DONE);
   assign response = response_q;
   assign tie      = tie_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ro_puf_reader.sv
// tb/tb_ro_puf_reader.sv - scoreboard bench for ro_puf_reader
// Instance 0 uses default sizing; instance 1 uses CNT_W=4, SEL_W=3 and a short window.
module tb_ro_puf_reader;

   typedef struct {
      logic [3:0] resp;
      logic [3:0] tie;
      logic [3:0] err;
      int         lat;
      int         t0;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst = 2'b11;
   logic [1:0]  start = 2'b00;
   logic [15:0] chal0 = '0;
   logic [23:0] chal1 = '0;
   logic [3:0]  ro_in  [2];
   logic [3:0]  ro_en  [2];
   logic [3:0]  response [2];
   logic [3:0]  tie    [2];
   logic [3:0]  err    [2];
   logic [1:0]  busy, done;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cnt [2];
   int   ph [2][4];
   bit   ro2_seen = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   exp_t last_e [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ro_puf_reader #(.NUM_RO(4), .SEL_W(2), .NUM_BITS(4), .CNT_W(16), .SETTLE(8), .WINDOW(1024)) u_dut0 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .challenge(chal0), .ro_in(ro_in[0]),
      .ro_en(ro_en[0]), .busy(busy[0]), .done(done[0]), .response(response[0]),
      .tie(tie[0]), .err(err[0]));

   ro_puf_reader #(.NUM_RO(4), .SEL_W(3), .NUM_BITS(4), .CNT_W(4), .SETTLE(8), .WINDOW(128)) u_dut1 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .challenge(chal1), .ro_in(ro_in[1]),
      .ro_en(ro_en[1]), .busy(busy[1]), .done(done[1]), .response(response[1]),
      .tie(tie[1]), .err(err[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // half-period (cycles between toggles) of each modelled oscillator
   function automatic int per(int n, int k);
      if (n == 0) begin
         case (k)
            0:       return 2;
            1:       return 4;
            2:       return 6;
            default: return 3;
         endcase
      end
      return (k % 2 == 0) ? 2 : 3;
   endfunction

   function automatic logic [23:0] mk(int sw, int a0, int b0, int a1, int b1,
                                      int a2, int b2, int a3, int b3);
      logic [23:0] r;
      r = 24'((b0 << sw) | a0);
      r = r | (24'((b1 << sw) | a1) << (2*sw));
      r = r | (24'((b2 << sw) | a2) << (4*sw));
      r = r | (24'((b3 << sw) | a3) << (6*sw));
      return r;
   endfunction

   // expected counts come from oscillator rate alone: about WINDOW/(2*half-period) edges
   function automatic exp_t model(int n, logic [23:0] ch);
      exp_t e;
      int sw, win, cmax, a, b, ea, eb;
      sw   = (n == 0) ? 2 : 3;
      win  = (n == 0) ? 1024 : 128;
      cmax = (n == 0) ? 65535 : 15;
      e.resp = '0; e.tie = '0; e.err = '0; e.lat = 1; e.t0 = 0;
      for (int i = 0; i < 4; i++) begin
         a = int'(ch >> (2*sw*i)) & ((1 << sw) - 1);
         b = int'(ch >> (2*sw*i + sw)) & ((1 << sw) - 1);
         if (a == b || a >= 4 || b >= 4) begin
            e.err[i] = 1'b1;
            e.lat += 2;
         end else begin
            ea = win / (2*per(n, a));
            eb = win / (2*per(n, b));
            if (ea > cmax) ea = cmax;
            if (eb > cmax) eb = cmax;
            e.resp[i] = (ea > eb);
            e.tie[i]  = (ea == eb);
            e.lat += 1 + 8 + win + 2;
         end
      end
      return e;
   endfunction

   initial begin
      for (int n = 0; n < 2; n++) begin
         ro_in[n] = '0;
         for (int k = 0; k < 4; k++) ph[n][k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 4; k++) begin
               if (!ro_en[n][k]) begin
                  ph[n][k] = 0;
                  ro_in[n][k] = 1'b0;
               end else begin
                  ph[n][k] = ph[n][k] + 1;
                  if (ph[n][k] >= per(n, k)) begin
                     ph[n][k] = 0;
                     ro_in[n][k] = ~ro_in[n][k];
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (ro_en[1][2]) ro2_seen = 1'b1;
      for (int n = 0; n < 2; n++) begin
         if (done[n] === 1'b1) begin
            exp_t e;
            done_cnt[n] = done_cnt[n] + 1;
            if ((n == 0 && sb0.size() == 0) || (n == 1 && sb1.size() == 0)) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = (n == 0) ? sb0.pop_front() : sb1.pop_front();
               last_e[n] = e;
               check("response", 32'(response[n]), 32'(e.resp));
               check("tie", 32'(tie[n]), 32'(e.tie));
               check("err", 32'(err[n]), 32'(e.err));
               check("latency", 32'(cyc - e.t0), 32'(e.lat));
               check("busy_at_done", 32'(busy[n]), 32'd0);
            end
         end
      end
   end

   task automatic do_start(input int n, input logic [23:0] ch, input bit expect_accept);
      exp_t e;
      @(negedge clk);
      if (n == 0) chal0 = ch[15:0]; else chal1 = ch;
      start[n] = 1'b1;
      if (expect_accept) begin
         e = model(n, ch);
         e.t0 = cyc;
         if (n == 0) sb0.push_back(e); else sb1.push_back(e);
      end
      @(negedge clk);
      start[n] = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      int c0;
      c0 = done_cnt[n];
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt[n] != c0) return;
      end
      check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_hold(input int n);
      repeat (5) @(negedge clk);
      check("hold_outputs", {20'd0, response[n], tie[n], err[n]},
            {20'd0, last_e[n].resp, last_e[n].tie, last_e[n].err});
   endtask

   initial begin
      int d0;
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      repeat (3) @(negedge clk);
      rst = 2'b00;
      repeat (10) @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         check("idle_ro_en", 32'(ro_en[n]), 32'd0);
         check("idle_busy_done", {30'd0, busy[n], done[n]}, 32'd0);
         check("idle_outputs", {20'd0, response[n], tie[n], err[n]}, 32'd0);
      end

      do_start(0, mk(2, 0,1, 1,0, 2,3, 3,2), 1'b1);
      check("busy_after_start", 32'(busy[0]), 32'd1);
      wait_done(0, 5000);
      check_hold(0);

      do_start(1, mk(3, 0,1, 1,0, 0,2, 1,3), 1'b1);
      wait_done(1, 1000);
      check_hold(1);

      @(negedge clk);
      ro2_seen = 1'b0;
      do_start(1, mk(3, 2,2, 0,5, 0,1, 1,0), 1'b1);
      wait_done(1, 1000);
      check("ro2_never_enabled", 32'(ro2_seen), 32'd0);

      do_start(0, mk(2, 0,1, 1,0, 2,3, 3,2), 1'b1);
      repeat (1544) @(negedge clk);
      check("ro_en_bit1_pair", 32'(ro_en[0]), 32'h3);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      check("rst_ro_en", 32'(ro_en[0]), 32'd0);
      check("rst_busy", 32'(busy[0]), 32'd0);
      sb0.delete();
      d0 = done_cnt[0];
      repeat (20) @(negedge clk);
      check("no_done_after_rst", 32'(done_cnt[0]), 32'(d0));

      do_start(0, mk(2, 1,2, 3,0, 2,0, 1,3), 1'b1);
      repeat (2000) @(negedge clk);
      do_start(0, mk(2, 0,1, 1,0, 2,3, 3,2), 1'b0);
      d0 = done_cnt[0];
      wait_done(0, 5000);
      repeat (10) @(negedge clk);
      check("single_done_busy_start", 32'(done_cnt[0]), 32'(d0 + 1));
      check("scoreboard_empty", 32'(sb0.size() + sb1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
